// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// Ovf is carried only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
`ifdef SERSUB_OVF_EN
  logic             Ovf;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Borrow, Ovf
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Borrow, Ovf
  );
`else
  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Borrow
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Borrow
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor Diff = A - B - Bin, LSB first, one full-subtractor cell.
// Define SERSUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bf;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             d;
  logic             b_next;

  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ bf;
    b_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bf);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // start is only honoured outside RUN, so a DONE cycle can chain straight into a new op
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  // On the last RUN edge the operand LSBs hold the original MSBs, which feed Ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bf         <= 1'b0;
      cnt        <= '0;
      bus.Diff   <= '0;
      bus.Borrow <= 1'b0;
`ifdef SERSUB_OVF_EN
      bus.Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= bus.A;
      b_sh <= bus.B;
      bf   <= bus.Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {d, res_sh[WIDTH-1:1]};
      bf     <= b_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        bus.Diff   <= {d, res_sh[WIDTH-1:1]};
        bus.Borrow <= b_next;
`ifdef SERSUB_OVF_EN
        bus.Ovf    <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); Ovf is checked when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;
  int   doneCount;
  int   pushCount;
  int   cycle;
  int   lastDoneCycle;
  bit   btbMode;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH:0] full;
    exp_t           e;
    full     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.diff   = full[WIDTH-1:0];
    e.borrow = full[WIDTH];
    e.ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ full[WIDTH-1]);
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      exp_t e;
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("diff", 32'(bus.Diff), 32'(e.diff));
        checkOutput("borrow", 32'(bus.Borrow), 32'(e.borrow));
`ifdef SERSUB_OVF_EN
        checkOutput("ovf", 32'(bus.Ovf), 32'(e.ovf));
`endif
      end
      if (btbMode && lastDoneCycle >= 0) begin
        checkOutput("done_spacing", 32'(cycle - lastDoneCycle), 32'(WIDTH + 1));
      end
      lastDoneCycle = cycle;
    end
  end

  // Called just after a rising edge; the next edge samples start
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin, input bit push);
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    if (push) begin
      sb.push_back(model(a, b, bin));
      pushCount++;
    end
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    exp_t e;
    e = model(a, b, bin);
    applyStimulus(a, b, bin, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    bus.Bin   = 1'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      checkOutput("busy_run", 32'(bus.busy), 32'd1);
      checkOutput("done_early", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    checkOutput("done_latency", 32'(bus.done), 32'd1);
    checkOutput("busy_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("done_pulse", 32'(bus.done), 32'd0);
    checkOutput("diff_hold", 32'(bus.Diff), 32'(e.diff));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    doneCount     = 0;
    pushCount     = 0;
    cycle         = 0;
    lastDoneCycle = -1;
    btbMode       = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;

    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_diff", 32'(bus.Diff), 32'd0);
    checkOutput("rst_borrow", 32'(bus.Borrow), 32'd0);
`ifdef SERSUB_OVF_EN
    checkOutput("rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("idle_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] directed operations");
    runOp(4'b0101, 4'b0011, 1'b0);
    runOp(4'b0000, 4'b0001, 1'b0);
    runOp(4'b1101, 4'b1101, 1'b1);
    runOp(4'b1000, 4'b0001, 1'b0);
    runOp(4'b0111, 4'b1111, 1'b0);
    runOp(4'b1111, 4'b1111, 1'b1);

    $display("[TB] start pulse during RUN");
    applyStimulus(4'b0101, 4'b0011, 1'b0, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] reset during RUN");
    applyStimulus(4'b1001, 4'b0100, 1'b0, 1'b0);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_diff", 32'(bus.Diff), 32'd0);
    checkOutput("abort_borrow", 32'(bus.Borrow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("post_abort_busy", 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1;
    runOp(4'b0110, 4'b0010, 1'b1);

    $display("[TB] random operations");
    for (int i = 0; i < 10; i++) begin
      runOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    $display("[TB] back-to-back with start held");
    btbMode       = 1'b1;
    lastDoneCycle = -1;
    applyStimulus(4'b1000, 4'b0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'b0111, 4'b1111, 1'b0, 1'b1);
    repeat (WIDTH + 1) @(posedge clk);
    #1 applyStimulus(4'b0011, 4'b0101, 1'b1, 1'b1);
    repeat (WIDTH + 1) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1 btbMode = 1'b0;

    checkOutput("done_count", 32'(doneCount), 32'(pushCount));
    checkOutput("queue_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
